// File: rtl/checker_dispatch_pkg.sv
// Shared types and constants for the checker start/end protocol initiator.
package checker_dispatch_pkg;

    // Width of the mode field on both the host command and the checker bus.
    localparam int MODE_W = 2;

    // Largest number of checker cores the mode field can address.
    localparam int MAX_MODES = 4;

    // Dispatcher sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    // Result status codes returned with every command.
    typedef enum logic [1:0] {
        RES_OK       = 2'b00,
        RES_TIMEOUT  = 2'b01,
        RES_ABORTED  = 2'b10,
        RES_BAD_MODE = 2'b11
    } res_status_e;

    // True when a command mode addresses a core that exists on this bus.
    function automatic logic mode_in_range(input logic [MODE_W-1:0] mode, input int num_modes);
        return int'(mode) < num_modes;
    endfunction

endpackage

// File: rtl/checker_dispatch_if.sv
// Host command/result channel plus the shared checker bus, bundled for the dispatcher.
interface checker_dispatch_if #(
    parameter int NUM_MODES = 4,
    parameter int CNT_W     = 32
);
    // Host command side
    logic                                     cmd_valid;
    logic                                     cmd_ready;
    logic [checker_dispatch_pkg::MODE_W-1:0]  cmd_mode;
    logic [63:0]                              cmd_addr;
    logic [CNT_W-1:0]                         cfg_timeout;
    logic                                     abort;
    logic                                     busy;

    // Result side
    logic                                     res_valid;
    logic [1:0]                               res_status;
    logic [7:0]                               res_ctrl;
    logic [CNT_W-1:0]                         res_cycles;

    // Shared checker bus
    logic [checker_dispatch_pkg::MODE_W-1:0]  cmode;
    logic                                     cstart;
    logic [63:0]                              caddr;
    logic [NUM_MODES-1:0]                     cend;
    logic [8*NUM_MODES-1:0]                   cctrl;

    // The dispatcher drives commands onto the checker bus and returns results.
    modport master (
        input  cmd_valid, cmd_mode, cmd_addr, cfg_timeout, abort, cend, cctrl,
        output cmd_ready, busy, res_valid, res_status, res_ctrl, res_cycles,
               cmode, cstart, caddr
    );

    // Host plus checker cores: the opposite view of the same signals.
    modport slave (
        output cmd_valid, cmd_mode, cmd_addr, cfg_timeout, abort, cend, cctrl,
        input  cmd_ready, busy, res_valid, res_status, res_ctrl, res_cycles,
               cmode, cstart, caddr
    );

endinterface

// File: rtl/checker_resp_mux.sv
// Selects the addressed core's end flag and control byte from the checker bus.
// Modes with no core behind them read back as "not ended, control zero".
module checker_resp_mux
    import checker_dispatch_pkg::*;
#(
    parameter int NUM_MODES = 4
) (
    input  logic [MODE_W-1:0]      sel,
    input  logic [NUM_MODES-1:0]   cend,
    input  logic [8*NUM_MODES-1:0] cctrl,
    output logic                   sel_end,
    output logic [7:0]             sel_ctrl
);

    // Pick cend/cctrl of the core whose index equals sel.
    always_comb begin
        sel_end  = 1'b0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (sel == MODE_W'(i)) begin
                sel_end  = cend[i];
                sel_ctrl = cctrl[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/checker_dispatch.sv
// Initiator for the checker start/end protocol. Accepts one host command at a
// time, raises cstart to the addressed core, waits for its end flag under abort
// and timeout control, and returns one registered result per command.
module checker_dispatch
    import checker_dispatch_pkg::*;
#(
    parameter int NUM_MODES = 4,
    parameter int CNT_W     = 32
) (
    input logic                sys_clk,
    input logic                sys_rst,
    checker_dispatch_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Registered state and outputs
    state_e             state_q,      state_d;
    logic               cstart_q,     cstart_d;
    logic [MODE_W-1:0]  cmode_q,      cmode_d;
    logic [63:0]        caddr_q,      caddr_d;
    logic [CNT_W-1:0]   timeout_q,    timeout_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               abort_pend_q, abort_pend_d;
    logic               res_valid_q,  res_valid_d;
    res_status_e        res_status_q, res_status_d;
    logic [7:0]         res_ctrl_q,   res_ctrl_d;
    logic [CNT_W-1:0]   res_cycles_q, res_cycles_d;
    logic               cmd_ready_q,  cmd_ready_d;
    logic               busy_q,       busy_d;

    // Selected core response and helper terms
    logic               sel_end;
    logic [7:0]         sel_ctrl;
    logic               accept;
    logic               abort_now;
    logic               timeout_hit;
    logic [CNT_W-1:0]   cnt_inc;

    // Response select uses the latched mode so it stays on one core for the whole run.
    checker_resp_mux #(
        .NUM_MODES (NUM_MODES)
    ) u_resp_mux (
        .sel      (cmode_q),
        .cend     (bus.cend),
        .cctrl    (bus.cctrl),
        .sel_end  (sel_end),
        .sel_ctrl (sel_ctrl)
    );

    assign accept      = bus.cmd_valid & cmd_ready_q;
    assign abort_now   = bus.abort | abort_pend_q;
    assign timeout_hit = (timeout_q != '0) && (cnt_q == timeout_q - CNT_ONE);
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Next-state and next-output decode for the IDLE/ARM/WAIT/RELEASE sequence.
    always_comb begin
        // NOTE: every variable is given its hold value first so no branch of the case leaves one unassigned and infers a latch.
        state_d      = state_q;
        cstart_d     = cstart_q;
        cmode_d      = cmode_q;
        caddr_d      = caddr_q;
        timeout_d    = timeout_q;
        cnt_d        = cnt_q;
        abort_pend_d = abort_pend_q;
        res_valid_d  = 1'b0;
        res_status_d = res_status_q;
        res_ctrl_d   = res_ctrl_q;
        res_cycles_d = res_cycles_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cmode_d   = bus.cmd_mode;
                    caddr_d   = bus.cmd_addr;
                    timeout_d = bus.cfg_timeout;
                    if (!mode_in_range(bus.cmd_mode, NUM_MODES)) begin
                        // No core behind this mode: answer at once and never start.
                        res_valid_d  = 1'b1;
                        res_status_d = RES_BAD_MODE;
                        res_ctrl_d   = '0;
                        res_cycles_d = '0;
                    end else begin
                        cstart_d     = 1'b1;
                        abort_pend_d = 1'b0;
                        state_d      = ARM;
                    end
                end
            end

            ARM: begin
                // The core still shows the previous run's sticky cend here, so it
                // is not looked at; an abort arriving now is held for WAIT.
                cnt_d   = '0;
                state_d = WAIT;
                if (bus.abort) begin
                    abort_pend_d = 1'b1;
                end
            end

            WAIT: begin
                if (abort_now || sel_end || timeout_hit) begin
                    cstart_d     = 1'b0;
                    abort_pend_d = 1'b0;
                    res_valid_d  = 1'b1;
                    res_cycles_d = cnt_inc;
                    state_d      = RELEASE;
                    if (abort_now) begin
                        res_status_d = RES_ABORTED;
                        res_ctrl_d   = '0;
                    end else if (sel_end) begin
                        // cctrl is captured on the edge that drops cstart, before
                        // any brief re-arm by the core can disturb it.
                        res_status_d = RES_OK;
                        res_ctrl_d   = sel_ctrl;
                    end else begin
                        res_status_d = RES_TIMEOUT;
                        res_ctrl_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            RELEASE: begin
                // One guaranteed low cycle on cstart; the result pulse is visible now.
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                cstart_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
        if (sys_rst) begin
            state_q      <= IDLE;
            cstart_q     <= 1'b0;
            cmode_q      <= '0;
            caddr_q      <= '0;
            timeout_q    <= '0;
            cnt_q        <= '0;
            abort_pend_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_status_q <= RES_OK;
            res_ctrl_q   <= '0;
            res_cycles_q <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cstart_q     <= cstart_d;
            cmode_q      <= cmode_d;
            caddr_q      <= caddr_d;
            timeout_q    <= timeout_d;
            cnt_q        <= cnt_d;
            abort_pend_q <= abort_pend_d;
            res_valid_q  <= res_valid_d;
            res_status_q <= res_status_d;
            res_ctrl_q   <= res_ctrl_d;
            res_cycles_q <= res_cycles_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.busy       = busy_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_status = res_status_q;
    assign bus.res_ctrl   = res_ctrl_q;
    assign bus.res_cycles = res_cycles_q;
    assign bus.cmode      = cmode_q;
    assign bus.cstart     = cstart_q;
    assign bus.caddr      = caddr_q;

endmodule

// File: tb/tb_checker_dispatch.sv
// Directed bench for checker_dispatch: a four-core instance with a counting
// dummy core on mode 2, and a two-core instance for the bad-mode path.
module tb_checker_dispatch;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;
    localparam logic [1:0] ST_BADMODE = 2'b11;

    typedef struct packed {
        logic [1:0]  status;
        logic [7:0]  ctrl;
        logic [31:0] cycles;
    } exp_t;

    logic sys_clk;
    logic sys_rst;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t q4[$];
    exp_t q2[$];
    exp_t e4;
    exp_t e2;
    int   n_res4     = 0;
    int   n_res2     = 0;
    int   last_gap   = 0;
    int   low_run    = 0;
    int   cstart2_hi = 0;
    int   hi_count;
    int   guard;

    checker_dispatch_if #(.NUM_MODES(4), .CNT_W(32)) bus4 ();
    checker_dispatch_if #(.NUM_MODES(2), .CNT_W(32)) bus2 ();

    checker_dispatch #(.NUM_MODES(4), .CNT_W(32)) u_dut4 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus4)
    );

    checker_dispatch #(.NUM_MODES(2), .CNT_W(32)) u_dut2 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Dummy core on mode 2: counts cycles while started, ends when the count
    // reaches caddr, shows the count on cctrl, and keeps cend until the next start.
    logic        core_prev;
    logic        core_end;
    logic        core_run;
    logic [15:0] core_cnt;
    wire         core_start = bus4.cstart && (bus4.cmode == 2'd2);

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            core_prev <= 1'b0;
            core_end  <= 1'b0;
            core_run  <= 1'b0;
            core_cnt  <= '0;
        end else begin
            core_prev <= core_start;
            if (core_start && !core_prev) begin
                core_end <= 1'b0;
                core_cnt <= '0;
                core_run <= 1'b1;
            end else if (core_run && core_start) begin
                core_cnt <= core_cnt + 16'd1;
                if (core_cnt + 16'd1 == bus4.caddr[15:0]) begin
                    core_end <= 1'b1;
                    core_run <= 1'b0;
                end
            end
        end
    end

    // Cores 0, 1 and 3 permanently assert end with distinct control bytes.
    assign bus4.cend  = {1'b1, core_end, 2'b11};
    assign bus4.cctrl = {8'h44, core_cnt[7:0], 8'h22, 8'h11};
    assign bus2.cend  = 2'b11;
    assign bus2.cctrl = 16'h2211;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the four-core instance.
    always @(negedge sys_clk) begin
        if (bus4.res_valid === 1'b1) begin
            if (q4.size() == 0) begin
                check("dut4 spurious res_valid", 64'(bus4.res_valid), 64'd0);
            end else begin
                e4 = q4.pop_front();
                check("dut4 res_status", 64'(bus4.res_status), 64'(e4.status));
                check("dut4 res_ctrl",   64'(bus4.res_ctrl),   64'(e4.ctrl));
                check("dut4 res_cycles", 64'(bus4.res_cycles), 64'(e4.cycles));
                check("dut4 cstart low with result", 64'(bus4.cstart), 64'd0);
            end
            n_res4++;
        end
    end

    // Scoreboard for the two-core instance.
    always @(negedge sys_clk) begin
        if (bus2.res_valid === 1'b1) begin
            if (q2.size() == 0) begin
                check("dut2 spurious res_valid", 64'(bus2.res_valid), 64'd0);
            end else begin
                e2 = q2.pop_front();
                check("dut2 res_status", 64'(bus2.res_status), 64'(e2.status));
                check("dut2 res_ctrl",   64'(bus2.res_ctrl),   64'(e2.ctrl));
                check("dut2 res_cycles", 64'(bus2.res_cycles), 64'(e2.cycles));
            end
            n_res2++;
        end
        if (bus2.cstart === 1'b1) cstart2_hi++;
    end

    // Length of the most recent low stretch on cstart between two runs.
    always @(negedge sys_clk) begin
        if (bus4.cstart === 1'b1) begin
            if (low_run != 0) last_gap <= low_run;
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
    end

    task automatic issue4(input logic [1:0] mode, input logic [63:0] addr, input logic [31:0] tmo);
        int g;
        bus4.cmd_mode    = mode;
        bus4.cmd_addr    = addr;
        bus4.cfg_timeout = tmo;
        bus4.cmd_valid   = 1'b1;
        g = 0;
        @(negedge sys_clk);
        while (bus4.cmd_ready !== 1'b1 && g < 200) begin
            @(negedge sys_clk);
            g++;
        end
        if (g >= 200) check("dut4 cmd_ready wait budget", 64'(bus4.cmd_ready), 64'd1);
        @(posedge sys_clk); #1;
        bus4.cmd_valid = 1'b0;
    endtask

    task automatic wait_res4(input int target);
        int g;
        g = 0;
        while (n_res4 < target && g < 2000) begin
            @(posedge sys_clk); #1;
            g++;
        end
        if (n_res4 < target) check("dut4 result wait budget", 64'(n_res4), 64'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst          = 1'b1;
        bus4.cmd_valid   = 1'b0;
        bus4.cmd_mode    = '0;
        bus4.cmd_addr    = '0;
        bus4.cfg_timeout = '0;
        bus4.abort       = 1'b0;
        bus2.cmd_valid   = 1'b0;
        bus2.cmd_mode    = '0;
        bus2.cmd_addr    = '0;
        bus2.cfg_timeout = '0;
        bus2.abort       = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;

        // Reset state
        @(negedge sys_clk);
        check("reset cmd_ready",  64'(bus4.cmd_ready),  64'd1);
        check("reset busy",       64'(bus4.busy),       64'd0);
        check("reset cstart",     64'(bus4.cstart),     64'd0);
        check("reset res_valid",  64'(bus4.res_valid),  64'd0);
        check("reset cmode",      64'(bus4.cmode),      64'd0);
        check("reset caddr",      bus4.caddr,           64'd0);
        check("reset res_status", 64'(bus4.res_status), 64'd0);
        check("reset res_ctrl",   64'(bus4.res_ctrl),   64'd0);
        check("reset res_cycles", 64'(bus4.res_cycles), 64'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        // Abort while idle has no effect
        bus4.abort = 1'b1;
        @(posedge sys_clk); #1;
        bus4.abort = 1'b0;
        @(negedge sys_clk);
        check("idle abort busy",      64'(bus4.busy),      64'd0);
        check("idle abort cmd_ready", 64'(bus4.cmd_ready), 64'd1);
        @(posedge sys_clk); #1;

        // 1: core ends after 5 counts; six WAIT cycles
        q4.push_back(exp_t'{ST_OK, 8'h05, 32'd6});
        issue4(2'd2, 64'd5, 32'd0);
        @(negedge sys_clk);
        check("t1 cstart one cycle after accept", 64'(bus4.cstart), 64'd1);
        check("t1 busy",      64'(bus4.busy),      64'd1);
        check("t1 cmd_ready", 64'(bus4.cmd_ready), 64'd0);
        check("t1 cmode",     64'(bus4.cmode),     64'd2);
        check("t1 caddr",     bus4.caddr,          64'd5);
        @(posedge sys_clk); #1;
        wait_res4(1);

        // 2: back-to-back; the stale cend seen in ARM must not end the second run
        q4.push_back(exp_t'{ST_OK, 8'h03, 32'd4});
        issue4(2'd2, 64'd3, 32'd0);
        q4.push_back(exp_t'{ST_OK, 8'h01, 32'd2});
        issue4(2'd2, 64'd1, 32'd0);
        wait_res4(3);
        check("t2 cstart low gap", 64'(last_gap), 64'd2);

        // 3: timeout of 10 with a slow core; ARM plus ten WAIT cycles of cstart
        q4.push_back(exp_t'{ST_TIMEOUT, 8'h00, 32'd10});
        issue4(2'd2, 64'd1000, 32'd10);
        hi_count = 0;
        guard    = 0;
        @(negedge sys_clk);
        while (bus4.cstart === 1'b1 && guard < 100) begin
            hi_count++;
            guard++;
            @(negedge sys_clk);
        end
        check("t3 cstart high cycles", 64'(hi_count), 64'd11);
        @(posedge sys_clk); #1;
        wait_res4(4);

        // 4: abort in the same cycle the selected cend rises; abort wins
        q4.push_back(exp_t'{ST_ABORT, 8'h00, 32'd5});
        issue4(2'd2, 64'd4, 32'd0);
        guard = 0;
        @(negedge sys_clk);
        while (core_end !== 1'b1 && guard < 100) begin
            guard++;
            @(negedge sys_clk);
        end
        check("t4 core end seen", 64'(core_end), 64'd1);
        bus4.abort = 1'b1;
        @(posedge sys_clk); #1;
        bus4.abort = 1'b0;
        wait_res4(5);

        // Abort raised during ARM takes effect on the first WAIT cycle
        q4.push_back(exp_t'{ST_ABORT, 8'h00, 32'd1});
        issue4(2'd2, 64'd50, 32'd0);
        bus4.abort = 1'b1;
        @(posedge sys_clk); #1;
        bus4.abort = 1'b0;
        wait_res4(6);

        // 5: two-core instance, mode 3 has no core behind it
        q2.push_back(exp_t'{ST_BADMODE, 8'h00, 32'd0});
        bus2.cmd_mode    = 2'd3;
        bus2.cmd_addr    = 64'h77;
        bus2.cfg_timeout = 32'd5;
        bus2.cmd_valid   = 1'b1;
        @(negedge sys_clk);
        check("t5 cmd_ready before accept", 64'(bus2.cmd_ready), 64'd1);
        @(posedge sys_clk); #1;
        bus2.cmd_valid = 1'b0;
        @(negedge sys_clk);
        check("t5 res_valid next cycle", 64'(bus2.res_valid), 64'd1);
        check("t5 cmd_ready stays",      64'(bus2.cmd_ready), 64'd1);
        check("t5 busy stays low",       64'(bus2.busy),      64'd0);
        repeat (4) @(posedge sys_clk);
        #1;
        check("t5 cstart never rose", 64'(cstart2_hi), 64'd0);
        check("t5 result count",      64'(n_res2),     64'd1);

        // 6: reset during WAIT drops the run with no result
        issue4(2'd2, 64'd1000, 32'd0);
        repeat (3) @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        check("t6 busy before reset", 64'(bus4.busy), 64'd1);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("t6 cstart after reset",     64'(bus4.cstart),     64'd0);
        check("t6 busy after reset",       64'(bus4.busy),       64'd0);
        check("t6 cmd_ready after reset",  64'(bus4.cmd_ready),  64'd1);
        check("t6 res_valid after reset",  64'(bus4.res_valid),  64'd0);
        check("t6 res_status after reset", 64'(bus4.res_status), 64'd0);
        repeat (10) @(posedge sys_clk);
        #1;
        check("t6 no result after reset", 64'(n_res4), 64'd6);

        check("dut4 scoreboard drained", 64'(q4.size()), 64'd0);
        check("dut2 scoreboard drained", 64'(q2.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
